// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first,
// with a single registered borrow. Result registers update only on completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;

  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_r;
  logic             ovf_r;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ br;
    br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    res_next = {d, res_sh[WIDTH-1:1]};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          res_sh <= res_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          if (last_bit) begin
            // Publish from res_next so the final bit lands together with the rest.
            diff_r   <= res_next;
            borrow_r <= br_next;
            ovf_r    <= (a_msb != b_msb) & (d != a_msb);
            done_r   <= 1'b1;
            cnt      <= '0;
            state    <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_r;
  assign bus.ovf        = ovf_r;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes DIFF = A - B one bit per clock, LSB first, using a single registered borrow.
- It is the subtract counterpart of the combinational full adder used in the uart2ahb datapath.
- Used where area matters more than latency, e.g. address/length decrement and checksum compare in the uart2ahb bridge.
- Start/done handshake; operands are captured on start, and the result is held until the next completion.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured when start is accepted.
- b  input  WIDTH  subtrahend; captured when start is accepted.
- busy  output  1  high from the accept edge until the DONE cycle ends.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result A-B, modulo 2^WIDTH; held between operations.
- borrow_out  output  1  final borrow; 1 when unsigned A < B.
- ovf  output  1  signed overflow of A-B.

Behaviour:
- Reset (rst_n=0 at an edge):
  - Interface: state=IDLE; busy, done, diff, borrow_out and ovf all 0.
  - Internal: operand shift registers, borrow and bit counter all cleared.
  - Reset mid-operation aborts the operation: no done pulse, and no partial result appears on diff.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: load a_sh<=a and b_sh<=b, capture a[WIDTH-1] and b[WIDTH-1] for ovf, borrow<=0, cnt<=0, busy<=1, state<=SHIFT.
  - start=0: stay in IDLE.
- SHIFT, at each edge:
  - Bit op: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br), where a0/b0 are the shift-register LSBs and br is the current borrow.
  - d shifts into the result register from the MSB side; a_sh and b_sh shift right; borrow<=br_next; cnt++.
- SHIFT exit: at the edge where cnt==WIDTH-1 (edge E_WIDTH):
  - diff<=the full result including this bit;
  - borrow_out<=br_next;
  - ovf<=(a_msb!=b_msb) & (d!=a_msb), where d is this final bit (the result MSB);
  - done<=1; state<=DONE.
- DONE: next edge sets done<=0, busy<=0, state<=IDLE.
- Timing:
  - Latency: done is high during the cycle following edge E_WIDTH, i.e. WIDTH edges after the accept edge.
  - Throughput: one operation per WIDTH+2 cycles; an accept is possible again in the cycle after DONE.
- start ignored while busy=1, including the DONE cycle. It is not queued and has no effect on the running operation.
- a and b may change freely after the accept edge without affecting the result.
- diff, borrow_out and ovf update only at edge E_WIDTH. They are stable at all other times, including while the next operation is in SHIFT.
- The internal result shift register is separate from diff, so diff never shows partial bits.
- cnt width is clog2(WIDTH); no wrap-around beyond WIDTH-1.
- Equivalence requirement: diff must equal (a-b) mod 2^WIDTH and borrow_out must equal (a<b unsigned), for every operand pair.

Test Plan:
- WIDTH=8, a=5, b=3, start 1 cycle -> done exactly 8 edges after the accept edge; diff=0x02, borrow_out=0, ovf=0; busy high for 9 cycles.
- a=3, b=5 -> diff=0xFE, borrow_out=1, ovf=0.
- a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1. a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
- Start held high continuously, with a/b changed every cycle during SHIFT:
  - first result uses the operands from the accept edge;
  - start is ignored through DONE;
  - a second accept occurs on the first IDLE cycle;
  - diff stays at the first result until the second done.
- rst_n=0 for 1 cycle in the 4th SHIFT cycle -> no done, all outputs 0 next cycle. A following start with a=0xAA, b=0x55 -> diff=0x55, borrow_out=0, ovf=1.
- Random sweep of 1000 operand pairs, WIDTH=8 and WIDTH=13 -> diff, borrow_out and ovf match a reference model; done pulse is always one cycle wide.
